// File: rtl/mem_dump_unit_if.sv
// Bus bundle for mem_dump_unit: dump request/abort controls, status flags,
// the memory read port and the valid/ready byte output stream.
interface mem_dump_unit_if #(
    parameter int word_size = 8,
    parameter int addr_size = 8
);
    logic                 start;
    logic [addr_size-1:0] start_addr;
    logic [addr_size-1:0] end_addr;
    logic                 abort;
    logic                 busy;
    logic                 done;
    logic                 cpu_hold;
    logic                 mem_rd_en;
    logic [addr_size-1:0] mem_rd_addr;
    logic [word_size-1:0] mem_rd_data;
    logic                 dout_valid;
    logic                 dout_ready;
    logic [word_size-1:0] dout_data;
    logic [addr_size-1:0] dout_addr;

    // Dump unit side
    modport slave (
        input  start, start_addr, end_addr, abort, mem_rd_data, dout_ready,
        output busy, done, cpu_hold, mem_rd_en, mem_rd_addr,
               dout_valid, dout_data, dout_addr
    );

    // Controller / memory / sink side
    modport master (
        output start, start_addr, end_addr, abort, mem_rd_data, dout_ready,
        input  busy, done, cpu_hold, mem_rd_en, mem_rd_addr,
               dout_valid, dout_data, dout_addr
    );
endinterface

// File: rtl/mem_dump_unit.sv
// mem_dump_unit: walks an inclusive, wrapping address range of the RISC_SPM
// memory one word at a time (issue read, capture data, hand off on
// valid/ready) and holds the CPU off the bus for the whole dump.
module mem_dump_unit #(
    parameter int word_size = 8,
    parameter int addr_size = 8
) (
    input logic            clk,
    input logic            rst,
    mem_dump_unit_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        SEND    = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [addr_size-1:0] ADDR_ONE = {{(addr_size-1){1'b0}}, 1'b1};
    localparam logic [addr_size:0]   REM_ONE  = {{addr_size{1'b0}}, 1'b1};

    state_t               state_reg;
    logic [addr_size-1:0] cur_reg;
    // One bit wider than an address so a full sweep (2**addr_size words) fits.
    logic [addr_size:0]   remaining_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 rd_en_reg;
    logic [addr_size-1:0] rd_addr_reg;
    logic                 valid_reg;
    logic [word_size-1:0] dout_data_reg;
    logic [addr_size-1:0] dout_addr_reg;

    logic [addr_size:0]   span_next;
    logic [addr_size-1:0] cur_inc;

    // Word count of the requested range; end < start wraps through the top.
    always_comb begin
        span_next = {1'b0, bus.end_addr - bus.start_addr} + REM_ONE;
        cur_inc   = cur_reg + ADDR_ONE;
    end

    // Dump sequencer; every output is a register written here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cur_reg       <= '0;
            remaining_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            rd_en_reg     <= 1'b0;
            rd_addr_reg   <= '0;
            valid_reg     <= 1'b0;
            dout_data_reg <= '0;
            dout_addr_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        cur_reg       <= bus.start_addr;
                        remaining_reg <= span_next;
                        busy_reg      <= 1'b1;
                        rd_en_reg     <= 1'b1;
                        rd_addr_reg   <= bus.start_addr;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Read strobe lasts exactly this one cycle.
                    rd_en_reg <= 1'b0;
                    if (bus.abort) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        state_reg <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (bus.abort) begin
                        // Returning read data is simply never captured.
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        dout_data_reg <= bus.mem_rd_data;
                        dout_addr_reg <= cur_reg;
                        valid_reg     <= 1'b1;
                        state_reg     <= SEND;
                    end
                end
                SEND: begin
                    if (bus.abort) begin
                        // The only case where valid drops without a handshake.
                        valid_reg <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else if (valid_reg && bus.dout_ready) begin
                        valid_reg     <= 1'b0;
                        remaining_reg <= remaining_reg - REM_ONE;
                        cur_reg       <= cur_inc;
                        if (remaining_reg == REM_ONE) begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            rd_en_reg   <= 1'b1;
                            rd_addr_reg <= cur_inc;
                            state_reg   <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.cpu_hold    = busy_reg;
    assign bus.done        = done_reg;
    assign bus.mem_rd_en   = rd_en_reg;
    assign bus.mem_rd_addr = rd_addr_reg;
    assign bus.dout_valid  = valid_reg;
    assign bus.dout_data   = dout_data_reg;
    assign bus.dout_addr   = dout_addr_reg;
endmodule

// File: tb/tb_mem_dump_unit.sv
// Bench for mem_dump_unit: a memory with one-cycle registered read, a sink
// with selectable ready patterns, and a per-cycle reference model of what a
// dump of [start..end] must deliver.
module tb_mem_dump_unit;
    localparam int WS = 8;
    localparam int AS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_dump_unit_if #(.word_size(WS), .addr_size(AS)) bus();
    mem_dump_unit #(.word_size(WS), .addr_size(AS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Memory: data returns one cycle after the read strobe.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model and per-cycle comparison ----------------
    typedef enum int {M_IDLE, M_RUN, M_DONE} mphase_t;
    mphase_t    phase = M_IDLE;
    int         exp_n, xfer, reads, cyc, done_count, done_cyc;
    logic [7:0] exp_addr_q[$], exp_data_q[$], got_addr_q[$], got_data_q[$];
    bit         stalled, aborted, post_rst, word_read;
    bit         prev_valid, prev_xfer, prev_abort, prev_rd;
    logic [7:0] prev_data, prev_addr;

    always @(negedge clk) begin
        bit xfer_now;
        if (rst) begin
            phase      = M_IDLE;
            post_rst   = 1'b1;
            prev_valid = 1'b0;
            prev_rd    = 1'b0;
        end else begin
            xfer_now = bus.dout_valid && bus.dout_ready;
            chk("cpu_hold_eq_busy", int'(bus.cpu_hold), int'(bus.busy));
            if (bus.done) done_count++;
            case (phase)
                M_IDLE: begin
                    chk("idle_busy", int'(bus.busy), 0);
                    chk("idle_done", int'(bus.done), 0);
                    chk("idle_valid", int'(bus.dout_valid), 0);
                    chk("idle_rd_en", int'(bus.mem_rd_en), 0);
                    if (post_rst) begin
                        chk("rst_rd_addr", int'(bus.mem_rd_addr), 0);
                        chk("rst_dout_data", int'(bus.dout_data), 0);
                        chk("rst_dout_addr", int'(bus.dout_addr), 0);
                    end
                    if (bus.start) begin
                        exp_n = ((int'(bus.end_addr) - int'(bus.start_addr) + 256) % 256) + 1;
                        exp_addr_q.delete();
                        exp_data_q.delete();
                        for (int i = 0; i < exp_n; i++) begin
                            logic [7:0] a;
                            a = 8'((int'(bus.start_addr) + i) % 256);
                            exp_addr_q.push_back(a);
                            exp_data_q.push_back(mem[a]);
                        end
                        got_addr_q.delete();
                        got_data_q.delete();
                        xfer = 0; reads = 0; cyc = 0;
                        stalled = 0; aborted = 0; word_read = 0; post_rst = 0;
                        phase = M_RUN;
                    end
                end
                M_RUN: begin
                    cyc++;
                    chk("run_busy", int'(bus.busy), 1);
                    chk("run_done", int'(bus.done), 0);
                    if (bus.mem_rd_en) begin
                        chk("rd_while_valid", int'(bus.dout_valid), 0);
                        chk("rd_back_to_back", int'(prev_rd), 0);
                        chk("rd_addr", int'(bus.mem_rd_addr), int'(exp_addr_q[xfer]));
                        chk("rd_once_per_word", int'(word_read), 0);
                        word_read = 1;
                        reads++;
                    end
                    if (bus.dout_valid) begin
                        chk("valid_after_read", int'(word_read), 1);
                        chk("dout_data", int'(bus.dout_data), int'(exp_data_q[xfer]));
                        chk("dout_addr", int'(bus.dout_addr), int'(exp_addr_q[xfer]));
                    end
                    if (prev_valid && !prev_xfer && !prev_abort) begin
                        chk("valid_held", int'(bus.dout_valid), 1);
                        chk("data_stable", int'(bus.dout_data), int'(prev_data));
                        chk("addr_stable", int'(bus.dout_addr), int'(prev_addr));
                    end
                    if (bus.dout_valid && !bus.dout_ready) stalled = 1;
                    if (xfer_now) begin
                        got_addr_q.push_back(bus.dout_addr);
                        got_data_q.push_back(bus.dout_data);
                        xfer++;
                        word_read = 0;
                    end
                    if (bus.abort) begin
                        aborted = 1;
                        phase = M_DONE;
                    end else if (xfer_now && xfer == exp_n) begin
                        phase = M_DONE;
                    end
                end
                M_DONE: begin
                    cyc++;
                    chk("done_pulse", int'(bus.done), 1);
                    chk("done_busy", int'(bus.busy), 1);
                    chk("done_valid", int'(bus.dout_valid), 0);
                    chk("done_rd_en", int'(bus.mem_rd_en), 0);
                    if (!aborted) chk("reads_total", reads, exp_n);
                    if (!aborted && !stalled) chk("done_latency", cyc, 3 * exp_n + 1);
                    done_cyc = cyc;
                    phase = M_IDLE;
                end
                default: phase = M_IDLE;
            endcase
            prev_valid = bus.dout_valid;
            prev_data  = bus.dout_data;
            prev_addr  = bus.dout_addr;
            prev_xfer  = xfer_now;
            prev_abort = bus.abort;
            prev_rd    = bus.mem_rd_en;
        end
    end

    // ---------------- sink ready / abort driver ----------------
    int rdy_mode  = 0;   // 0: always ready, 1: random, 2: low 5 cycles per word
    bit abort_req = 0;
    bit abort_rnd = 0;
    initial begin
        int vcnt = 0;
        bus.dout_ready = 1'b0;
        bus.abort      = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            vcnt = bus.dout_valid ? vcnt + 1 : 0;
            case (rdy_mode)
                0:       bus.dout_ready = 1'b1;
                1:       bus.dout_ready = ($urandom % 3) != 0;
                default: bus.dout_ready = (vcnt > 5);
            endcase
            bus.abort = abort_req || (abort_rnd && ($urandom % 40) == 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start(input logic [7:0] s, input logic [7:0] e);
        @(posedge clk);
        #2;
        bus.start      = 1'b1;
        bus.start_addr = s;
        bus.end_addr   = e;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (phase != M_IDLE && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("dump_finished_in_budget", int'(phase == M_IDLE), 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic run_dump(input logic [7:0] s, input logic [7:0] e, input int budget);
        pulse_start(s, e);
        wait_idle(budget);
    endtask

    task automatic chk_words(input string tag, input int d0, input int d1,
                             input int d2, input int d3, input int a0);
        int lit_d[4];
        lit_d = '{d0, d1, d2, d3};
        chk({tag, "_count"}, got_data_q.size(), 4);
        if (got_data_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk({tag, "_data"}, int'(got_data_q[i]), lit_d[i]);
                chk({tag, "_addr"}, int'(got_addr_q[i]), (a0 + i) % 256);
            end
        end
    endtask

    initial begin
        int dc;
        int n;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.end_addr   = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[128] = 8'd6; mem[129] = 8'd1; mem[130] = 8'd2; mem[131] = 8'd0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);

        // 1: basic dump, ready tied high
        dc = done_count;
        rdy_mode = 0;
        run_dump(8'd128, 8'd131, 100);
        chk_words("t1", 6, 1, 2, 0, 128);
        chk("t1_done_cycle", done_cyc, 13);
        chk("t1_done_once", done_count - dc, 1);

        // 2: sink stalls each word
        rdy_mode = 2;
        run_dump(8'd128, 8'd131, 200);
        chk_words("t2", 6, 1, 2, 0, 128);

        // 3: wrapping range, then single word
        mem[254] = 8'hAA; mem[255] = 8'hBB; mem[0] = 8'h51; mem[1] = 8'h01;
        mem[140] = 8'h3C;
        rdy_mode = 1;
        run_dump(8'd254, 8'd1, 200);
        chk_words("t3", 'hAA, 'hBB, 'h51, 'h01, 254);
        dc = done_count;
        run_dump(8'd140, 8'd140, 100);
        chk("t3_single_count", got_data_q.size(), 1);
        if (got_data_q.size() == 1) begin
            chk("t3_single_data", int'(got_data_q[0]), 'h3C);
            chk("t3_single_addr", int'(got_addr_q[0]), 140);
        end
        chk("t3_single_done", done_count - dc, 1);

        // 4: full 256-word sweep
        dc = done_count;
        rdy_mode = 0;
        run_dump(8'd0, 8'd255, 1000);
        chk("t4_count", got_data_q.size(), 256);
        if (got_addr_q.size() == 256) chk("t4_last_addr", int'(got_addr_q[255]), 255);
        chk("t4_done_cycle", done_cyc, 769);
        chk("t4_done_once", done_count - dc, 1);

        // 5: abort during second word, with an ignored start while busy
        mem[128] = 8'd6; mem[129] = 8'd1; mem[130] = 8'd2; mem[131] = 8'd0;
        dc = done_count;
        rdy_mode = 2;
        pulse_start(8'd128, 8'd131);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(xfer == 1 && bus.dout_valid) && n < 100);
        chk("t5_reached_word2", int'(xfer == 1 && bus.dout_valid), 1);
        bus.start = 1'b1; bus.start_addr = 8'd0; bus.end_addr = 8'd5;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        abort_req = 1'b1;
        @(posedge clk);
        #2;
        abort_req = 1'b0;
        wait_idle(50);
        repeat (4) @(posedge clk);
        chk("t5_words_before_abort", got_data_q.size(), 1);
        chk("t5_aborted", int'(aborted), 1);
        chk("t5_done_once", done_count - dc, 1);
        chk("t5_no_restart", int'(bus.busy), 0);

        // 6: reset during CAPTURE, then a normal dump
        dc = done_count;
        rdy_mode = 0;
        pulse_start(8'd128, 8'd131);
        n = 0;
        while (!(phase == M_RUN && cyc == 1) && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        chk("t6_no_done", done_count - dc, 0);
        run_dump(8'd128, 8'd131, 100);
        chk_words("t6", 6, 1, 2, 0, 128);

        // Randomized dumps with random ready and sporadic aborts
        for (int it = 0; it < 25; it++) begin
            logic [7:0] s, e;
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            s = 8'($urandom);
            e = 8'(int'(s) + $urandom_range(0, 23));
            rdy_mode  = $urandom % 2;
            abort_rnd = ($urandom % 3) == 0;
            run_dump(s, e, 2000);
            abort_rnd = 1'b0;
            repeat (2) @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
